// File: rtl/uart_axi_pkg.sv
// Shared constants for the AXI4-Lite UART register bank: register map, status/control bit
// positions, response codes and the write/read channel state encodings.
package uart_axi_pkg;

  localparam logic [2:0] REG_RXDATA = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  localparam int ST_RX_NEMPTY    = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_RX_OVF       = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_TX_FLUSH  = 2;
  localparam int CTRL_RX_FLUSH  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_RESP} rd_state_t;

  // The map only occupies byte offsets 0x00..0x1F; anything above decodes as an error.
  function automatic logic addr_in_map(input logic [31:0] addr);
    return addr[31:5] == 27'd0;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head word, occupancy count and a flush that
// overrides any same-cycle push or pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = head_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_ptr_next = pop_ok ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Head is prefetched from the next read address; a write landing on that slot
  // (FIFO about to be empty) is forwarded so the new word is visible next cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      head_reg <= '0;
    end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= push_data;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_ok);
      rd_ptr_reg <= rd_ptr_next;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/s_axi_lite_uart_fifo.sv
// AXI4-Lite register bank in front of the UART byte engines: TX/RX FIFOs, sticky RX
// overflow, flush controls and a registered level interrupt.
module s_axi_lite_uart_fifo
  import uart_axi_pkg::*;
#(
  parameter int P_S_AXI_DATA_WIDTH = 32,
  parameter int P_S_AXI_ADDR_WIDTH = 5,
  parameter int P_UART_DATA_WIDTH  = 8,
  parameter int P_TX_FIFO_DEPTH    = 16,
  parameter int P_RX_FIFO_DEPTH    = 16
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [P_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [P_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [P_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic                            i_user_rx_valid,
  input  logic [P_UART_DATA_WIDTH-1:0]    i_user_rx_data,
  output logic                            o_user_tx_valid,
  output logic [P_UART_DATA_WIDTH-1:0]    o_user_tx_data,
  input  logic                            i_user_tx_ready,
  output logic                            o_irq
);

  localparam int DW    = P_S_AXI_DATA_WIDTH;
  localparam int UW    = P_UART_DATA_WIDTH;
  localparam int TX_CW = $clog2(P_TX_FIFO_DEPTH) + 1;
  localparam int RX_CW = $clog2(P_RX_FIFO_DEPTH) + 1;

  wr_state_t         wr_state_reg, wr_state_next;
  rd_state_t         rd_state_reg, rd_state_next;
  logic              wr_hs, rd_hs;
  logic [1:0]        bresp_reg, bresp_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic [DW-1:0]     rdata_reg, rdata_next;
  logic [1:0]        ctrl_en_reg, ctrl_en_next;
  logic              rx_ovf_reg, ovf_clr;
  logic              irq_reg;
  logic              tx_push, tx_flush, rx_pop, rx_flush;
  logic [UW-1:0]     tx_head, rx_head;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic [DW-1:0]     status_word;
  logic              unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata, s_axi_wstrb,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  uart_sync_fifo #(.WIDTH(UW), .DEPTH(P_TX_FIFO_DEPTH)) u_tx_fifo (
    .clk       (s_axi_aclk),
    .srst      (s_axi_areset),
    .push      (tx_push),
    .push_data (s_axi_wdata[UW-1:0]),
    .pop       (i_user_tx_ready),
    .flush     (tx_flush),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  uart_sync_fifo #(.WIDTH(UW), .DEPTH(P_RX_FIFO_DEPTH)) u_rx_fifo (
    .clk       (s_axi_aclk),
    .srst      (s_axi_areset),
    .push      (i_user_rx_valid),
    .push_data (i_user_rx_data),
    .pop       (rx_pop),
    .flush     (rx_flush),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Ready is a one-cycle pulse from the ACK state, so the handshake edge is simply "in ACK".
  assign wr_hs = (wr_state_reg == WR_ACK);
  assign rd_hs = (rd_state_reg == RD_ACK);

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      WR_IDLE: if (s_axi_awvalid && s_axi_wvalid) wr_state_next = WR_ACK;
      WR_ACK:  wr_state_next = WR_RESP;
      WR_RESP: if (s_axi_bready) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (s_axi_arvalid) rd_state_next = RD_ACK;
      RD_ACK:  rd_state_next = RD_RESP;
      RD_RESP: if (s_axi_rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    bresp_next   = RESP_DECERR;
    tx_push      = 1'b0;
    tx_flush     = 1'b0;
    rx_flush     = 1'b0;
    ovf_clr      = 1'b0;
    ctrl_en_next = ctrl_en_reg;
    if (addr_in_map(32'(s_axi_awaddr))) begin
      case (s_axi_awaddr[4:2])
        REG_TXDATA: begin
          if (s_axi_wstrb[0] && tx_full) begin
            bresp_next = RESP_SLVERR;
          end else begin
            bresp_next = RESP_OKAY;
            tx_push    = wr_hs && s_axi_wstrb[0];
          end
        end
        REG_STATUS: begin
          bresp_next = RESP_OKAY;
          ovf_clr    = wr_hs && s_axi_wstrb[0] && s_axi_wdata[ST_RX_OVF];
        end
        REG_CTRL: begin
          bresp_next = RESP_OKAY;
          if (wr_hs && s_axi_wstrb[0]) begin
            ctrl_en_next = s_axi_wdata[1:0];
            tx_flush     = s_axi_wdata[CTRL_TX_FLUSH];
            rx_flush     = s_axi_wdata[CTRL_RX_FLUSH];
          end
        end
        default: bresp_next = RESP_DECERR;
      endcase
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_RX_NEMPTY] = !rx_empty;
    status_word[ST_RX_FULL]   = rx_full;
    status_word[ST_TX_EMPTY]  = tx_empty;
    status_word[ST_TX_FULL]   = tx_full;
    status_word[ST_RX_OVF]    = rx_ovf_reg;
    status_word[ST_RX_COUNT_LSB +: RX_CW] = rx_count;
    status_word[ST_TX_COUNT_LSB +: TX_CW] = tx_count;
  end

  always_comb begin
    rdata_next = '0;
    rresp_next = RESP_DECERR;
    rx_pop     = 1'b0;
    if (addr_in_map(32'(s_axi_araddr))) begin
      case (s_axi_araddr[4:2])
        REG_RXDATA: begin
          if (rx_empty) begin
            rresp_next = RESP_SLVERR;
          end else begin
            rresp_next           = RESP_OKAY;
            rdata_next[UW-1:0]   = rx_head;
            rx_pop               = rd_hs;
          end
        end
        REG_STATUS: begin
          rresp_next = RESP_OKAY;
          rdata_next = status_word;
        end
        REG_CTRL: begin
          rresp_next      = RESP_OKAY;
          rdata_next[1:0] = ctrl_en_reg;
        end
        default: rresp_next = RESP_DECERR;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  // A new overflow in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      bresp_reg   <= RESP_OKAY;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
      ctrl_en_reg <= '0;
      rx_ovf_reg  <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      if (wr_hs) bresp_reg <= bresp_next;
      if (rd_hs) begin
        rresp_reg <= rresp_next;
        rdata_reg <= rdata_next;
      end
      ctrl_en_reg <= ctrl_en_next;
      rx_ovf_reg  <= (i_user_rx_valid && rx_full) || (rx_ovf_reg && !ovf_clr);
      irq_reg     <= (ctrl_en_reg[CTRL_RX_IRQ_EN] && !rx_empty) ||
                     (ctrl_en_reg[CTRL_TX_IRQ_EN] && tx_empty) || rx_ovf_reg;
    end
  end

  assign s_axi_awready   = wr_hs;
  assign s_axi_wready    = wr_hs;
  assign s_axi_bvalid    = (wr_state_reg == WR_RESP);
  assign s_axi_bresp     = bresp_reg;
  assign s_axi_arready   = rd_hs;
  assign s_axi_rvalid    = (rd_state_reg == RD_RESP);
  assign s_axi_rresp     = rresp_reg;
  assign s_axi_rdata     = rdata_reg;
  assign o_user_tx_valid = !tx_empty;
  assign o_user_tx_data  = tx_head;
  assign o_irq           = irq_reg;

endmodule

// File: tb/tb_s_axi_lite_uart_fifo.sv
// Self-checking bench: vector table of register accesses plus directed sequences for
// FIFO fill/overflow, flush, interrupt and back-pressure, all checked via scoreboards.
module tb_s_axi_lite_uart_fifo;

  logic        clk = 1'b0;
  logic        areset;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        rx_valid, tx_valid, tx_ready, irq;
  logic [7:0]  rx_data, tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct packed {
    bit          rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] tx_q[$];
  vec_t       vecs[10];

  always #5 clk = ~clk;

  s_axi_lite_uart_fifo dut (
    .s_axi_aclk      (clk),
    .s_axi_areset    (areset),
    .s_axi_awaddr    (awaddr),
    .s_axi_awprot    (awprot),
    .s_axi_awvalid   (awvalid),
    .s_axi_awready   (awready),
    .s_axi_wdata     (wdata),
    .s_axi_wstrb     (wstrb),
    .s_axi_wvalid    (wvalid),
    .s_axi_wready    (wready),
    .s_axi_bresp     (bresp),
    .s_axi_bvalid    (bvalid),
    .s_axi_bready    (bready),
    .s_axi_araddr    (araddr),
    .s_axi_arprot    (arprot),
    .s_axi_arvalid   (arvalid),
    .s_axi_arready   (arready),
    .s_axi_rdata     (rdata),
    .s_axi_rresp     (rresp),
    .s_axi_rvalid    (rvalid),
    .s_axi_rready    (rready),
    .i_user_rx_valid (rx_valid),
    .i_user_rx_data  (rx_data),
    .o_user_tx_valid (tx_valid),
    .o_user_tx_data  (tx_data),
    .i_user_tx_ready (tx_ready),
    .o_irq           (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // TX consumer model: every accepted byte must match the scoreboard order.
  always @(negedge clk) begin
    if (!areset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected_pop", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int stall, input string tag);
    exp_t e;
    logic [1:0] r0;
    int t;
    e.data = '0;
    e.resp = exp_resp;
    sb_q.push_back(e);
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!(awready && wready) && t < 20);
    if (!(awready && wready)) begin
      check({tag, "_aw_timeout"}, 32'(awready), 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    e = sb_q.pop_front();
    if (!bvalid) begin
      check({tag, "_b_timeout"}, 32'(bvalid), 32'd1);
      return;
    end
    r0 = bresp;
    check({tag, "_bresp"}, 32'(bresp), 32'(e.resp));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_bvalid_hold"}, 32'(bvalid), 32'd1);
      check({tag, "_bresp_hold"}, 32'(bresp), 32'(r0));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
    $display("WR %-10s addr=0x%02h data=0x%08h strb=%b bresp=%b", tag, addr, data, strb, r0);
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int stall, input string tag);
    exp_t e;
    logic [31:0] d0;
    int t;
    e.data = exp_data;
    e.resp = exp_resp;
    sb_q.push_back(e);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 20);
    if (!arready) begin
      check({tag, "_ar_timeout"}, 32'(arready), 32'd1);
      arvalid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    e = sb_q.pop_front();
    if (!rvalid) begin
      check({tag, "_r_timeout"}, 32'(rvalid), 32'd1);
      return;
    end
    d0 = rdata;
    check({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
    check({tag, "_rdata"}, rdata, e.data);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_rvalid_hold"}, 32'(rvalid), 32'd1);
      check({tag, "_rdata_hold"}, rdata, d0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    $display("RD %-10s addr=0x%02h rdata=0x%08h rresp=%b", tag, addr, d0, rresp);
  endtask

  task automatic rx_strobe(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
    $display("RX strobe data=0x%02h", d);
  endtask

  initial begin
    vecs[0] = '{rd: 1'b0, addr: 5'h04, wdata: 32'h41, exp: 32'h0,         resp: 2'b00};
    vecs[1] = '{rd: 1'b1, addr: 5'h08, wdata: 32'h0,  exp: 32'h0001_0000, resp: 2'b00};
    vecs[2] = '{rd: 1'b1, addr: 5'h0C, wdata: 32'h0,  exp: 32'h0,         resp: 2'b00};
    vecs[3] = '{rd: 1'b0, addr: 5'h0C, wdata: 32'h3,  exp: 32'h0,         resp: 2'b00};
    vecs[4] = '{rd: 1'b1, addr: 5'h0C, wdata: 32'h0,  exp: 32'h3,         resp: 2'b00};
    vecs[5] = '{rd: 1'b0, addr: 5'h0C, wdata: 32'h0,  exp: 32'h0,         resp: 2'b00};
    vecs[6] = '{rd: 1'b1, addr: 5'h14, wdata: 32'h0,  exp: 32'h0,         resp: 2'b11};
    vecs[7] = '{rd: 1'b0, addr: 5'h00, wdata: 32'h55, exp: 32'h0,         resp: 2'b11};
    vecs[8] = '{rd: 1'b0, addr: 5'h1C, wdata: 32'h0,  exp: 32'h0,         resp: 2'b11};
    vecs[9] = '{rd: 1'b1, addr: 5'h00, wdata: 32'h0,  exp: 32'h0,         resp: 2'b10};

    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    rx_valid = 0; rx_data = '0; tx_ready = 0;
    repeat (4) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);

    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_irq",     32'(irq),     32'd0);
    check("rst_txvalid", 32'(tx_valid), 32'd0);

    tx_q.push_back(8'h41);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rd)
        axi_read(vecs[i].addr, vecs[i].exp, vecs[i].resp, 0, $sformatf("vec%0d", i));
      else
        axi_write(vecs[i].addr, vecs[i].wdata, 4'h1, vecs[i].resp, 0, $sformatf("vec%0d", i));
    end
    check("tx_valid_after_push", 32'(tx_valid), 32'd1);
    check("tx_data_after_push",  32'(tx_data),  32'h41);

    // Fill the TX FIFO to its 16 entries; the 17th write must be refused.
    for (int i = 1; i < 16; i++) begin
      tx_q.push_back(8'(i));
      axi_write(5'h04, 32'(i), 4'h1, 2'b00, 0, "tx_fill");
    end
    axi_write(5'h04, 32'hEE, 4'h1, 2'b10, 0, "tx_over");
    axi_read(5'h08, 32'h0010_0008, 2'b00, 0, "st_txfull");

    @(posedge clk); #1 tx_ready = 1'b1;
    for (int t = 0; t < 100 && tx_valid; t++) @(negedge clk);
    tx_ready = 1'b0;
    check("tx_drained", 32'(tx_q.size()), 32'd0);

    for (int i = 0; i < 3; i++) axi_write(5'h04, 32'hA0 + 32'(i), 4'h1, 2'b00, 0, "tx_q3");
    axi_read(5'h08, 32'h0003_0000, 2'b00, 0, "st_tx3");
    axi_write(5'h0C, 32'h4, 4'h1, 2'b00, 0, "tx_flush");
    axi_read(5'h08, 32'h0000_0004, 2'b00, 0, "st_flushed");
    axi_read(5'h0C, 32'h0, 2'b00, 0, "ctrl_selfclr");

    check("irq_before_en", 32'(irq), 32'd0);
    axi_write(5'h0C, 32'h2, 4'h1, 2'b00, 0, "ctrl_txirq");
    check("irq_tx_empty", 32'(irq), 32'd1);
    axi_write(5'h0C, 32'h0, 4'h1, 2'b00, 0, "ctrl_off");
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'd0);

    rx_strobe(8'h11);
    rx_strobe(8'h22);
    axi_read(5'h00, 32'h11, 2'b00, 0, "rx_pop1");
    axi_read(5'h00, 32'h22, 2'b00, 0, "rx_pop2");
    axi_read(5'h00, 32'h00, 2'b10, 0, "rx_empty");

    for (int i = 0; i < 17; i++) rx_strobe(8'h80 + 8'(i));
    axi_read(5'h08, 32'h0000_1017, 2'b00, 0, "st_rxovf");
    check("irq_ovf", 32'(irq), 32'd1);
    axi_read(5'h00, 32'h80, 2'b00, 0, "rx_first");
    axi_write(5'h08, 32'h10, 4'h1, 2'b00, 0, "ovf_w1c");
    axi_read(5'h08, 32'h0000_0F05, 2'b00, 0, "st_ovfclr");
    check("irq_ovf_clr", 32'(irq), 32'd0);
    axi_write(5'h0C, 32'h8, 4'h1, 2'b00, 0, "rx_flush");
    axi_read(5'h08, 32'h0000_0004, 2'b00, 0, "st_rxflush");

    axi_write(5'h0C, 32'h1, 4'h1, 2'b00, 5, "stall_wr");
    rx_strobe(8'h5A);
    @(negedge clk);
    check("irq_rx_nempty", 32'(irq), 32'd1);
    axi_read(5'h00, 32'h5A, 2'b00, 5, "stall_rd");
    axi_read(5'h14, 32'h0, 2'b11, 0, "unmapped");

    // Reset while a write is in flight: the response must never appear.
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h77; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("rst_mid_awready", 32'(awready), 32'd0);
    check("rst_mid_bvalid",  32'(bvalid),  32'd0);
    areset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_bvalid_after", 32'(bvalid), 32'd0);
    axi_read(5'h08, 32'h0000_0004, 2'b00, 0, "st_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
